// File: rtl/seq_grid_ctrl.sv
// Step-sequencer grid controller: cursor movement, cell toggle/clear, and
// column-by-column playback, with one cell-draw job at a time on req/ack.
module seq_grid_ctrl #(
  parameter int ROWS  = 12,
  parameter int STEPS = 16,
  parameter int WRAP  = 0
) (
  input  logic                     CLOCK_50,
  input  logic                     nReset,
  input  logic [3:0]               Direction,
  input  logic                     Command,
  input  logic                     clear,
  input  logic                     play_en,
  input  logic                     bpm_step,
  output logic [ROWS-1:0]          select_note,
  output logic [$clog2(STEPS)-1:0] step_idx,
  output logic                     step_strobe,
  output logic [$clog2(STEPS)-1:0] cursor_x,
  output logic [$clog2(ROWS)-1:0]  cursor_y,
  output logic                     draw_req,
  input  logic                     draw_ack,
  output logic [$clog2(STEPS)-1:0] draw_x,
  output logic [$clog2(ROWS)-1:0]  draw_y,
  output logic                     draw_on,
  output logic                     draw_cursor
);

  localparam int XW = $clog2(STEPS);
  localparam int YW = $clog2(ROWS);
  localparam logic [XW-1:0] X_MAX = XW'(STEPS - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(ROWS - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRAW_OLD, S_DRAW_NEW, S_SWEEP} state_t;

  // Sync chains: [0] first flop, [1] second flop, [2] edge-detect history.
  logic [3:0] dir_s1, dir_s2, dir_q;
  logic [2:0] cmd_sync, clr_sync, bpm_sync;
  logic [1:0] play_sync;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, exactly like the synthesised chain.
  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      dir_s1    <= '0;
      dir_s2    <= '0;
      dir_q     <= '0;
      cmd_sync  <= '0;
      clr_sync  <= '0;
      bpm_sync  <= '0;
      play_sync <= '0;
    end else begin
      dir_s1    <= Direction;
      dir_s2    <= dir_s1;
      dir_q     <= dir_s2;
      cmd_sync  <= {cmd_sync[1:0], Command};
      clr_sync  <= {clr_sync[1:0], clear};
      bpm_sync  <= {bpm_sync[1:0], bpm_step};
      play_sync <= {play_sync[0], play_en};
    end
  end

  logic move_p, cmd_p, clr_p, bpm_p, play_lvl;
  assign move_p   = $onehot(dir_s2) && (dir_s2 != dir_q);
  assign cmd_p    = cmd_sync[1] & ~cmd_sync[2];
  assign clr_p    = clr_sync[1] & ~clr_sync[2];
  assign bpm_p    = bpm_sync[1] & ~bpm_sync[2];
  assign play_lvl = play_sync[1];

  logic [XW-1:0] next_x;
  logic [YW-1:0] next_y;

  // NOTE: defaults first so no path leaves next_x/next_y unassigned (no latch).
  always_comb begin
    next_x = cursor_x;
    next_y = cursor_y;
    case (dir_s2)
      4'b1000: next_x = (cursor_x == X_MAX) ? ((WRAP != 0) ? '0 : cursor_x) : cursor_x + 1'b1;
      4'b0100: next_x = (cursor_x == '0) ? ((WRAP != 0) ? X_MAX : cursor_x) : cursor_x - 1'b1;
      4'b0010: next_y = (cursor_y == Y_MAX) ? ((WRAP != 0) ? '0 : cursor_y) : cursor_y + 1'b1;
      4'b0001: next_y = (cursor_y == '0) ? ((WRAP != 0) ? Y_MAX : cursor_y) : cursor_y - 1'b1;
      default: ;
    endcase
  end

  state_t        state;
  logic [STEPS-1:0] grid [ROWS];
  logic [XW-1:0] old_x, sweep_x;
  logic [YW-1:0] old_y, sweep_y;

  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      state       <= S_IDLE;
      cursor_x    <= '0;
      cursor_y    <= '0;
      old_x       <= '0;
      old_y       <= '0;
      sweep_x     <= '0;
      sweep_y     <= '0;
      draw_req    <= 1'b0;
      draw_x      <= '0;
      draw_y      <= '0;
      draw_on     <= 1'b0;
      draw_cursor <= 1'b0;
      // NOTE: the grid is a small flop array, not a RAM, so it can and must
      // come out of reset cleared; a block RAM would need an explicit sweep.
      for (int r = 0; r < ROWS; r++) grid[r] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (clr_p) begin
            for (int r = 0; r < ROWS; r++) grid[r] <= '0;
            sweep_x <= '0;
            sweep_y <= '0;
            state   <= S_SWEEP;
          end else if (cmd_p) begin
            grid[cursor_y][cursor_x] <= ~grid[cursor_y][cursor_x];
            state <= S_DRAW_NEW;
          end else if (move_p) begin
            old_x    <= cursor_x;
            old_y    <= cursor_y;
            cursor_x <= next_x;
            cursor_y <= next_y;
            state    <= S_DRAW_OLD;
          end
        end
        S_DRAW_OLD: begin
          if (!draw_req) begin
            draw_req    <= 1'b1;
            draw_x      <= old_x;
            draw_y      <= old_y;
            draw_on     <= grid[old_y][old_x];
            draw_cursor <= 1'b0;
          end else if (draw_ack) begin
            draw_req <= 1'b0;
            state    <= S_DRAW_NEW;
          end
        end
        S_DRAW_NEW: begin
          if (!draw_req) begin
            draw_req    <= 1'b1;
            draw_x      <= cursor_x;
            draw_y      <= cursor_y;
            draw_on     <= grid[cursor_y][cursor_x];
            draw_cursor <= 1'b1;
          end else if (draw_ack) begin
            draw_req <= 1'b0;
            state    <= S_IDLE;
          end
        end
        S_SWEEP: begin
          if (!draw_req) begin
            draw_req    <= 1'b1;
            draw_x      <= sweep_x;
            draw_y      <= sweep_y;
            draw_on     <= grid[sweep_y][sweep_x];
            draw_cursor <= (sweep_x == cursor_x) && (sweep_y == cursor_y);
          end else if (draw_ack) begin
            draw_req <= 1'b0;
            if (sweep_x == X_MAX) begin
              sweep_x <= '0;
              if (sweep_y == Y_MAX) state <= S_IDLE;
              else sweep_y <= sweep_y + 1'b1;
            end else begin
              sweep_x <= sweep_x + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // play_ptr is the next column to sound; step_idx reports the column whose
  // notes are currently on select_note.
  logic [XW-1:0] play_ptr;

  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      select_note <= '0;
      step_idx    <= '0;
      step_strobe <= 1'b0;
      play_ptr    <= '0;
    end else begin
      step_strobe <= 1'b0;
      if (!play_lvl) begin
        select_note <= '0;
        step_idx    <= '0;
        play_ptr    <= '0;
      end else if (bpm_p) begin
        for (int r = 0; r < ROWS; r++) select_note[r] <= grid[r][play_ptr];
        step_idx    <= play_ptr;
        play_ptr    <= (play_ptr == X_MAX) ? '0 : play_ptr + 1'b1;
        step_strobe <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_grid_ctrl.sv
// Directed bench for seq_grid_ctrl: cursor moves, wrap/saturate, toggle and
// playback, handshake stall, clear sweep, and reset during a sweep.
module tb_seq_grid_ctrl;

  localparam int ROWS  = 12;
  localparam int STEPS = 16;

  logic        CLOCK_50 = 1'b0;
  logic        nReset   = 1'b0;
  logic [3:0]  Direction = '0;
  logic        Command = 1'b0, clear = 1'b0, play_en = 1'b0, bpm_step = 1'b0;
  logic        draw_ack = 1'b0;

  logic [ROWS-1:0] select_note;
  logic [3:0]      step_idx, cursor_x, draw_x;
  logic [3:0]      cursor_y, draw_y;
  logic            step_strobe, draw_req, draw_on, draw_cursor;

  logic [ROWS-1:0] w_select_note;
  logic [3:0]      w_step_idx, w_cursor_x, w_draw_x, w_cursor_y, w_draw_y;
  logic            w_step_strobe, w_draw_req, w_draw_on, w_draw_cursor;

  seq_grid_ctrl #(.ROWS(ROWS), .STEPS(STEPS), .WRAP(0)) dut (
    .CLOCK_50(CLOCK_50), .nReset(nReset), .Direction(Direction), .Command(Command),
    .clear(clear), .play_en(play_en), .bpm_step(bpm_step),
    .select_note(select_note), .step_idx(step_idx), .step_strobe(step_strobe),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .draw_req(draw_req), .draw_ack(draw_ack),
    .draw_x(draw_x), .draw_y(draw_y), .draw_on(draw_on), .draw_cursor(draw_cursor)
  );

  seq_grid_ctrl #(.ROWS(ROWS), .STEPS(STEPS), .WRAP(1)) dut_wrap (
    .CLOCK_50(CLOCK_50), .nReset(nReset), .Direction(Direction), .Command(Command),
    .clear(clear), .play_en(play_en), .bpm_step(bpm_step),
    .select_note(w_select_note), .step_idx(w_step_idx), .step_strobe(w_step_strobe),
    .cursor_x(w_cursor_x), .cursor_y(w_cursor_y), .draw_req(w_draw_req), .draw_ack(1'b1),
    .draw_x(w_draw_x), .draw_y(w_draw_y), .draw_on(w_draw_on), .draw_cursor(w_draw_cursor)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct { logic [3:0] jx; logic [3:0] jy; logic jon; logic jcur; } job_t;
  typedef struct { logic [3:0] idx; logic [ROWS-1:0] notes; } strobe_t;
  job_t    jobs[$];
  strobe_t strobes[$];

  int n_checks = 0;
  int n_fail   = 0;

  always @(posedge CLOCK_50)
    if (nReset && draw_req && draw_ack) jobs.push_back('{draw_x, draw_y, draw_on, draw_cursor});

  always @(negedge CLOCK_50)
    if (step_strobe) strobes.push_back('{step_idx, select_note});

  task automatic cycles(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    nReset = 1'b0; Direction = '0; Command = 1'b0; clear = 1'b0;
    play_en = 1'b0; bpm_step = 1'b0;
    cycles(3);
    nReset = 1'b1;
    cycles(2);
    jobs.delete();
    strobes.delete();
  endtask

  task automatic press_dir(input logic [3:0] d);
    Direction = d; cycles(4); Direction = '0; cycles(10);
  endtask

  task automatic press_cmd();
    Command = 1'b1; cycles(4); Command = 1'b0; cycles(8);
  endtask

  task automatic bpm_pulse();
    bpm_step = 1'b1; cycles(3); bpm_step = 1'b0; cycles(3);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (select_note !== '0) begin n_fail++; $display("FAIL reset_select_note got %0h want 0", select_note); end
    n_checks++; if (step_idx !== '0) begin n_fail++; $display("FAIL reset_step_idx got %0d want 0", step_idx); end
    n_checks++; if (step_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_step_strobe got %b want 0", step_strobe); end
    n_checks++; if ({cursor_x, cursor_y} !== 8'h00) begin n_fail++; $display("FAIL reset_cursor got %0d,%0d want 0,0", cursor_x, cursor_y); end
    n_checks++; if ({draw_req, draw_x, draw_y, draw_on, draw_cursor} !== 11'h0) begin
      n_fail++; $display("FAIL reset_draw got req=%b x=%0d y=%0d on=%b cur=%b want all 0", draw_req, draw_x, draw_y, draw_on, draw_cursor); end
  endtask

  task automatic test_move_right();
    do_reset();
    draw_ack = 1'b1;
    repeat (3) press_dir(4'b1000);
    n_checks++; if (cursor_x !== 4'd3 || cursor_y !== 4'd0) begin n_fail++; $display("FAIL move_cursor got %0d,%0d want 3,0", cursor_x, cursor_y); end
    n_checks++; if (jobs.size() !== 6) begin n_fail++; $display("FAIL move_job_count got %0d want 6", jobs.size()); end
    if (jobs.size() >= 6) begin
      n_checks++; if (jobs[0] !== '{4'd0, 4'd0, 1'b0, 1'b0}) begin n_fail++; $display("FAIL move_job0 got %0d,%0d,%b,%b want 0,0,0,0", jobs[0].jx, jobs[0].jy, jobs[0].jon, jobs[0].jcur); end
      n_checks++; if (jobs[1] !== '{4'd1, 4'd0, 1'b0, 1'b1}) begin n_fail++; $display("FAIL move_job1 got %0d,%0d,%b,%b want 1,0,0,1", jobs[1].jx, jobs[1].jy, jobs[1].jon, jobs[1].jcur); end
      n_checks++; if (jobs[4] !== '{4'd2, 4'd0, 1'b0, 1'b0}) begin n_fail++; $display("FAIL move_job4 got %0d,%0d,%b,%b want 2,0,0,0", jobs[4].jx, jobs[4].jy, jobs[4].jon, jobs[4].jcur); end
      n_checks++; if (jobs[5] !== '{4'd3, 4'd0, 1'b0, 1'b1}) begin n_fail++; $display("FAIL move_job5 got %0d,%0d,%b,%b want 3,0,0,1", jobs[5].jx, jobs[5].jy, jobs[5].jon, jobs[5].jcur); end
    end
    // Two directions at once is not a move.
    jobs.delete();
    press_dir(4'b1010);
    n_checks++; if (jobs.size() !== 0 || cursor_x !== 4'd3) begin n_fail++; $display("FAIL multi_dir got jobs=%0d x=%0d want 0,3", jobs.size(), cursor_x); end
  endtask

  task automatic test_wrap();
    do_reset();
    draw_ack = 1'b1;
    press_dir(4'b0100);
    n_checks++; if (cursor_x !== 4'd0) begin n_fail++; $display("FAIL sat_left got %0d want 0", cursor_x); end
    n_checks++; if (w_cursor_x !== 4'd15) begin n_fail++; $display("FAIL wrap_left got %0d want 15", w_cursor_x); end
    n_checks++; if (jobs.size() !== 2) begin n_fail++; $display("FAIL sat_job_count got %0d want 2", jobs.size()); end
    if (jobs.size() >= 2) begin
      n_checks++; if (jobs[0] !== '{4'd0, 4'd0, 1'b0, 1'b0} || jobs[1] !== '{4'd0, 4'd0, 1'b0, 1'b1}) begin
        n_fail++; $display("FAIL sat_jobs got (%0d,%0d,%b) (%0d,%0d,%b) want (0,0,0) (0,0,1)", jobs[0].jx, jobs[0].jy, jobs[0].jcur, jobs[1].jx, jobs[1].jy, jobs[1].jcur); end
    end
    press_dir(4'b0001);
    n_checks++; if (cursor_y !== 4'd0) begin n_fail++; $display("FAIL sat_up got %0d want 0", cursor_y); end
    n_checks++; if (w_cursor_y !== 4'd11) begin n_fail++; $display("FAIL wrap_up got %0d want 11", w_cursor_y); end
    press_dir(4'b1000);
    n_checks++; if (w_cursor_x !== 4'd0) begin n_fail++; $display("FAIL wrap_right got %0d want 0", w_cursor_x); end
    press_dir(4'b0010);
    n_checks++; if (w_cursor_y !== 4'd0) begin n_fail++; $display("FAIL wrap_down got %0d want 0", w_cursor_y); end
  endtask

  task automatic test_toggle_play();
    do_reset();
    draw_ack = 1'b1;
    repeat (2) press_dir(4'b1000);
    repeat (5) press_dir(4'b0010);
    n_checks++; if (cursor_x !== 4'd2 || cursor_y !== 4'd5) begin n_fail++; $display("FAIL nav_cursor got %0d,%0d want 2,5", cursor_x, cursor_y); end
    jobs.delete();
    press_cmd();
    n_checks++; if (jobs.size() !== 1) begin n_fail++; $display("FAIL toggle_job_count got %0d want 1", jobs.size()); end
    if (jobs.size() >= 1) begin
      n_checks++; if (jobs[0] !== '{4'd2, 4'd5, 1'b1, 1'b1}) begin n_fail++; $display("FAIL toggle_job got %0d,%0d,%b,%b want 2,5,1,1", jobs[0].jx, jobs[0].jy, jobs[0].jon, jobs[0].jcur); end
    end
    play_en = 1'b1;
    cycles(4);
    bpm_step = 1'b1;
    cycles(2);
    n_checks++; if (step_strobe !== 1'b0) begin n_fail++; $display("FAIL bpm_early got %b want 0", step_strobe); end
    cycles(1);
    n_checks++; if (step_strobe !== 1'b1) begin n_fail++; $display("FAIL bpm_latency got %b want 1", step_strobe); end
    bpm_step = 1'b0;
    cycles(1);
    n_checks++; if (step_strobe !== 1'b0) begin n_fail++; $display("FAIL strobe_width got %b want 0", step_strobe); end
    cycles(2);
    repeat (17) bpm_pulse();
    n_checks++; if (strobes.size() !== 18) begin n_fail++; $display("FAIL strobe_count got %0d want 18", strobes.size()); end
    for (int k = 0; k < strobes.size() && k < 18; k++) begin
      logic [3:0]      e_idx;
      logic [ROWS-1:0] e_notes;
      e_idx   = 4'(k % STEPS);
      e_notes = (e_idx == 4'd2) ? 12'h020 : 12'h000;
      n_checks++;
      if (strobes[k].idx !== e_idx || strobes[k].notes !== e_notes) begin
        n_fail++; $display("FAIL play_step%0d got idx=%0d notes=%h want idx=%0d notes=%h", k, strobes[k].idx, strobes[k].notes, e_idx, e_notes); end
    end
    play_en = 1'b0;
    cycles(4);
    n_checks++; if (step_idx !== 4'd0 || select_note !== '0) begin n_fail++; $display("FAIL play_off got idx=%0d notes=%h want 0,0", step_idx, select_note); end
  endtask

  task automatic test_stall();
    logic [10:0] held;
    int t;
    do_reset();
    draw_ack = 1'b0;
    Direction = 4'b1000; cycles(4); Direction = '0;
    t = 0;
    while (!draw_req && t < 20) begin cycles(1); t++; end
    n_checks++; if ({draw_req, draw_x, draw_y, draw_on, draw_cursor} !== {1'b1, 4'd0, 4'd0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL stall_first_job got req=%b x=%0d y=%0d on=%b cur=%b want 1,0,0,0,0", draw_req, draw_x, draw_y, draw_on, draw_cursor); end
    held = {draw_req, draw_x, draw_y, draw_on, draw_cursor};
    Command = 1'b1;
    for (int i = 0; i < 50; i++) begin
      cycles(1);
      n_checks++; if ({draw_req, draw_x, draw_y, draw_on, draw_cursor} !== held) begin
        n_fail++; $display("FAIL stall_hold%0d got %h want %h", i, {draw_req, draw_x, draw_y, draw_on, draw_cursor}, held); end
    end
    Command = 1'b0;
    draw_ack = 1'b1;
    cycles(15);
    n_checks++; if (jobs.size() !== 2) begin n_fail++; $display("FAIL stall_job_count got %0d want 2", jobs.size()); end
    if (jobs.size() >= 2) begin
      n_checks++; if (jobs[1] !== '{4'd1, 4'd0, 1'b0, 1'b1}) begin n_fail++; $display("FAIL stall_job1 got %0d,%0d,%b,%b want 1,0,0,1", jobs[1].jx, jobs[1].jy, jobs[1].jon, jobs[1].jcur); end
    end
    play_en = 1'b1;
    cycles(4);
    repeat (2) bpm_pulse();
    n_checks++; if (strobes.size() !== 2) begin n_fail++; $display("FAIL stall_strobes got %0d want 2", strobes.size()); end
    else begin
      n_checks++; if (strobes[0].notes !== '0 || strobes[1].notes !== '0) begin
        n_fail++; $display("FAIL stall_grid got %h %h want 0 0", strobes[0].notes, strobes[1].notes); end
    end
    play_en = 1'b0;
    cycles(4);
  endtask

  task automatic test_clear();
    int t, on_cnt, cur_cnt, cur_pos, order_err;
    do_reset();
    draw_ack = 1'b1;
    press_cmd();
    press_dir(4'b1000);
    press_cmd();
    play_en = 1'b1;
    cycles(4);
    bpm_pulse();
    n_checks++; if (strobes.size() !== 1 || strobes[0].notes !== 12'h001) begin
      n_fail++; $display("FAIL preclear_play got n=%0d notes=%h want 1,001", strobes.size(), (strobes.size() > 0) ? strobes[0].notes : 12'h0); end
    jobs.delete();
    clear = 1'b1; cycles(4); clear = 1'b0;
    t = 0;
    while ((jobs.size() < 192 || draw_req) && t < 1000) begin cycles(1); t++; end
    cycles(10);
    n_checks++; if (jobs.size() !== 192) begin n_fail++; $display("FAIL sweep_count got %0d want 192", jobs.size()); end
    on_cnt = 0; cur_cnt = 0; cur_pos = -1; order_err = 0;
    foreach (jobs[k]) begin
      if (jobs[k].jon) on_cnt++;
      if (jobs[k].jcur) begin cur_cnt++; cur_pos = k; end
      if (jobs[k].jx !== 4'(k % STEPS) || jobs[k].jy !== 4'(k / STEPS)) order_err++;
    end
    n_checks++; if (on_cnt !== 0) begin n_fail++; $display("FAIL sweep_on got %0d want 0", on_cnt); end
    n_checks++; if (cur_cnt !== 1 || cur_pos !== 1) begin n_fail++; $display("FAIL sweep_cursor got count=%0d pos=%0d want 1,1", cur_cnt, cur_pos); end
    n_checks++; if (order_err !== 0) begin n_fail++; $display("FAIL sweep_order got %0d bad want 0", order_err); end
    strobes.delete();
    bpm_pulse();
    n_checks++; if (strobes.size() !== 1) begin n_fail++; $display("FAIL postclear_strobes got %0d want 1", strobes.size()); end
    else begin
      n_checks++; if (strobes[0].notes !== '0 || strobes[0].idx !== 4'd1) begin
        n_fail++; $display("FAIL postclear_play got idx=%0d notes=%h want 1,000", strobes[0].idx, strobes[0].notes); end
    end
    play_en = 1'b0;
    cycles(4);
  endtask

  task automatic test_reset_mid_sweep();
    int t;
    do_reset();
    draw_ack = 1'b1;
    clear = 1'b1; cycles(4); clear = 1'b0;
    t = 0;
    while (jobs.size() < 40 && t < 400) begin cycles(1); t++; end
    n_checks++; if (jobs.size() < 40) begin n_fail++; $display("FAIL sweep_progress got %0d want >=40", jobs.size()); end
    t = 0;
    while (!draw_req && t < 5) begin cycles(1); t++; end
    #2 nReset = 1'b0;
    #1;
    n_checks++; if ({draw_req, draw_x, draw_y, draw_on, draw_cursor} !== 11'h0) begin
      n_fail++; $display("FAIL abort_draw got req=%b x=%0d y=%0d on=%b cur=%b want all 0", draw_req, draw_x, draw_y, draw_on, draw_cursor); end
    n_checks++; if ({select_note, step_idx, step_strobe, cursor_x, cursor_y} !== '0) begin
      n_fail++; $display("FAIL abort_outputs got notes=%h idx=%0d strobe=%b cur=%0d,%0d want 0", select_note, step_idx, step_strobe, cursor_x, cursor_y); end
    cycles(2);
    nReset = 1'b1;
    jobs.delete();
    cycles(20);
    n_checks++; if (draw_req !== 1'b0 || jobs.size() !== 0) begin n_fail++; $display("FAIL abort_idle got req=%b jobs=%0d want 0,0", draw_req, jobs.size()); end
    press_dir(4'b1000);
    n_checks++; if (jobs.size() !== 2 || cursor_x !== 4'd1) begin n_fail++; $display("FAIL abort_move got jobs=%0d x=%0d want 2,1", jobs.size(), cursor_x); end
  endtask

  initial begin
    test_reset();
    test_move_right();
    test_wrap();
    test_toggle_play();
    test_stall();
    test_clear();
    test_reset_mid_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "timeout");
  end

endmodule
